// File: rtl/dcache_warmup_pkg.sv
// Shared definitions for the dcache tag warm-up loader: FSM states and default geometry.
package dcache_warmup_pkg;

    localparam int SETS_DEF     = 64;
    localparam int WAYS_DEF     = 4;
    localparam int TAG_BITS_DEF = 22;
    localparam int ADDR_BITS    = $clog2(SETS_DEF);
    localparam int ROW_BITS     = WAYS_DEF * TAG_BITS_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        READ,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/dcache_tag_loader.sv
// Streams one tag row per set into the dcache tag SRAM, then optionally reads every
// row back and compares an XOR signature of what was written against what was read.
module dcache_tag_loader
    import dcache_warmup_pkg::*;
#(
    parameter int SETS     = SETS_DEF,
    parameter int WAYS     = WAYS_DEF,
    parameter int TAG_BITS = TAG_BITS_DEF,
    parameter bit VERIFY   = 1'b1,
    localparam int AW = (SETS == SETS_DEF) ? ADDR_BITS : ((SETS > 1) ? $clog2(SETS) : 1),
    localparam int RW = ((WAYS == WAYS_DEF) && (TAG_BITS == TAG_BITS_DEF)) ? ROW_BITS
                                                                            : WAYS * TAG_BITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RW-1:0]   in_tags,
    output logic [AW-1:0]   RW0_addr,
    output logic            RW0_en,
    output logic            RW0_wmode,
    output logic [RW-1:0]   RW0_wdata,
    output logic [WAYS-1:0] RW0_wmask,
    input  logic [RW-1:0]   RW0_rdata,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(SETS - 1);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    state_e          state_q, state_d;
    logic [AW:0]     set_cnt_q, set_cnt_d;
    logic [AW:0]     rd_cnt_q, rd_cnt_d;
    logic [RW-1:0]   wr_sum_q, wr_sum_d;
    logic [RW-1:0]   rd_sum_q, rd_sum_d;
    logic            error_q, error_d;
    logic            rd_vld_q, rd_vld_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [RW-1:0]   wr_data_q, wr_data_d;
    logic            rd_issue;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            set_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wr_sum_q  <= '0;
            rd_sum_q  <= '0;
            error_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_sum_q  <= wr_sum_d;
            rd_sum_q  <= rd_sum_d;
            error_q   <= error_d;
            rd_vld_q  <= rd_vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_sum_d  = wr_sum_q;
        rd_sum_d  = rd_sum_q;
        error_d   = error_q;
        rd_vld_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        // Read data lags its address by one cycle, so folding keys off last cycle's read.
        if (rd_vld_q) begin
            rd_sum_d = rd_sum_q ^ RW0_rdata;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    set_cnt_d = '0;
                    rd_cnt_d  = '0;
                    wr_sum_d  = '0;
                    rd_sum_d  = '0;
                    error_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = set_cnt_q[AW-1:0];
                    wr_data_d = in_tags;
                    wr_sum_d  = wr_sum_q ^ in_tags;
                    set_cnt_d = set_cnt_q + ONE;
                    if (set_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = VERIFY ? READ : DONE;
            end
            READ: begin
                rd_vld_d = 1'b1;
                rd_cnt_d = rd_cnt_q + ONE;
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                error_d = (rd_sum_d != wr_sum_q);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes come from the registered beat; reads are issued straight from the READ state.
    assign rd_issue  = (state_q == READ);
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q inside {LOAD, DRAIN, READ, CHECK});
    assign done      = (state_q == DONE);
    assign error     = error_q;
    assign RW0_en    = wr_en_q | rd_issue;
    assign RW0_wmode = wr_en_q;
    assign RW0_addr  = wr_en_q ? wr_addr_q : (rd_issue ? rd_cnt_q[AW-1:0] : '0);
    assign RW0_wdata = wr_data_q;
    assign RW0_wmask = {WAYS{wr_en_q}};

endmodule

// File: tb/tb_dcache_tag_loader.sv
// Bench for dcache_tag_loader: a VERIFY=0 and a VERIFY=1 instance share one stimulus stream,
// each paired with a 1-cycle-read SRAM model and an event-timeline reference model.
module tb_dcache_tag_loader;

    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int TB   = 22;
    localparam int AW   = 6;
    localparam int RW   = WAYS * TB;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic [RW-1:0]  in_tags;
    bit             corrupt;
    int             total = 0;
    int             bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit V   = (g == 1);
        localparam int LAT = V ? SETS + 3 : 2;

        logic            in_ready_w, busy_w, done_w, error_w, en_w, wm_w;
        logic [AW-1:0]   addr_w;
        logic [RW-1:0]   wdata_w;
        logic [WAYS-1:0] mask_w;
        logic [RW-1:0]   rdata_r = '0;
        logic [RW-1:0]   mem [SETS];

        dcache_tag_loader #(
            .SETS(SETS), .WAYS(WAYS), .TAG_BITS(TB), .VERIFY(V)
        ) dut (
            .clock(clk), .reset(rst), .start(start), .in_valid(in_valid),
            .in_ready(in_ready_w), .in_tags(in_tags), .RW0_addr(addr_w), .RW0_en(en_w),
            .RW0_wmode(wm_w), .RW0_wdata(wdata_w), .RW0_wmask(mask_w), .RW0_rdata(rdata_r),
            .busy(busy_w), .done(done_w), .error(error_w)
        );

        always @(posedge clk) begin : sram
            logic [RW-1:0] row;
            if (en_w) begin
                if (wm_w) begin
                    row = mem[addr_w];
                    for (int w = 0; w < WAYS; w++)
                        if (mask_w[w]) row[w*TB +: TB] = wdata_w[w*TB +: TB];
                    if (corrupt && addr_w == 6'd5) row[0] = ~row[0];
                    mem[addr_w] <= row;
                end else begin
                    rdata_r <= mem[addr_w];
                end
            end
        end

        // Reference: tracks accepted beats and the cycle of the last beat; every
        // later output (reads, busy, done, error) is a fixed offset from that cycle.
        int            cyc = 0, beats = 0, t_last = -1, wr_addr = 0;
        bit            loading = 0, wr_pend = 0, live = 0, m_err = 0;
        logic [RW-1:0] wr_xor = '0, wr_data = '0;

        always @(posedge clk) begin : model
            bit busy_now;
            busy_now = loading || (t_last >= 0 && cyc < t_last + LAT);
            wr_pend  = 0;
            if (rst) begin
                live = 1; loading = 0; beats = 0; t_last = -1; m_err = 0; wr_xor = '0;
            end else begin
                if (loading && in_valid) begin
                    wr_pend = 1; wr_addr = beats; wr_data = in_tags;
                    wr_xor  = wr_xor ^ in_tags;
                    beats++;
                    if (beats == SETS) begin
                        loading = 0; t_last = cyc;
                    end
                end
                if (start && !busy_now) begin
                    loading = 1; beats = 0; wr_xor = '0; t_last = -1; m_err = 0;
                end
            end
            cyc++;
        end

        always @(negedge clk) begin : cmp
            bit              rd, dn;
            int              ra;
            logic [RW-1:0]   fold, e_data;
            logic [WAYS-1:0] e_mask;
            logic [AW-1:0]   e_addr;
            if (live) begin
                rd = V && t_last >= 0 && cyc >= t_last + 2 && cyc <= t_last + 1 + SETS;
                ra = rd ? cyc - t_last - 2 : 0;
                dn = t_last >= 0 && cyc >= t_last + LAT;
                if (V && t_last >= 0 && cyc == t_last + LAT) begin
                    fold = '0;
                    for (int k = 0; k < SETS; k++) fold = fold ^ mem[k];
                    m_err = (fold != wr_xor);
                end
                e_addr = AW'(wr_pend ? wr_addr : ra);
                e_mask = wr_pend ? {WAYS{1'b1}} : {WAYS{1'b0}};
                e_data = wr_pend ? wr_data : {RW{1'b0}};
                chk1($sformatf("in_ready[v%0d] cyc %0d", g, cyc), in_ready_w, loading);
                chk1($sformatf("busy[v%0d] cyc %0d", g, cyc), busy_w, loading || (t_last >= 0 && !dn));
                chk1($sformatf("done[v%0d] cyc %0d", g, cyc), done_w, dn);
                chk1($sformatf("error[v%0d] cyc %0d", g, cyc), error_w, dn && m_err);
                chk($sformatf("rw0[v%0d] cyc %0d", g, cyc),
                    128'({en_w, wm_w, addr_w, mask_w, wdata_w}),
                    128'({wr_pend || rd, wr_pend, e_addr, e_mask, e_data}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit rnd_valid, input bit lit);
        int sent = 0;
        while (sent < n) begin
            in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (lit) begin
                for (int w = 0; w < WAYS; w++) in_tags[w*TB +: TB] = TB'(sent);
            end else begin
                in_tags = RW'({$urandom(), $urandom(), $urandom()});
            end
            tick();
            if (in_valid) sent++;
        end
        in_valid = 1'b0;
        in_tags  = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!g_inst[1].done_w && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk1("wait_done", g_inst[1].done_w, 1'b1);
    endtask

    task automatic check_rows();
        logic [RW-1:0] e;
        for (int k = 0; k < SETS; k++) begin
            e = '0;
            for (int w = 0; w < WAYS; w++) e[w*TB +: TB] = TB'(k);
            chk($sformatf("row_v1[%0d]", k), 128'(g_inst[1].mem[k]), 128'(e));
            chk($sformatf("row_v0[%0d]", k), 128'(g_inst[0].mem[k]), 128'(e));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_tags = '0; corrupt = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs", 128'({g_inst[1].in_ready_w, g_inst[1].busy_w, g_inst[1].done_w,
                               g_inst[1].error_w, g_inst[1].en_w, g_inst[1].wm_w}), 128'(0));
        rst = 1'b0;

        // in_valid while idle must not be accepted
        in_valid = 1'b1;
        in_tags  = RW'({$urandom(), $urandom(), $urandom()});
        repeat (4) tick();
        @(negedge clk);
        chk1("idle_in_ready", g_inst[1].in_ready_w, 1'b0);
        chk1("idle_no_write", g_inst[1].en_w, 1'b0);
        in_valid = 1'b0;

        // back-to-back literal load; both latencies pinned
        pulse_start();
        send_beats(SETS, 1'b0, 1'b1);
        @(negedge clk);
        chk("last_write", 128'({g_inst[1].en_w, g_inst[1].wm_w, g_inst[1].addr_w}),
            128'({2'b11, 6'd63}));
        chk1("v0_done_at_1", g_inst[0].done_w, 1'b0);
        tick();
        @(negedge clk);
        chk1("v0_done_at_2", g_inst[0].done_w, 1'b1);
        chk1("v0_busy_at_2", g_inst[0].busy_w, 1'b0);
        repeat (64) tick();
        @(negedge clk);
        chk1("v1_done_at_66", g_inst[1].done_w, 1'b0);
        tick();
        @(negedge clk);
        chk1("v1_done_at_67", g_inst[1].done_w, 1'b1);
        chk1("v1_error_clean", g_inst[1].error_w, 1'b0);
        check_rows();

        // gappy in_valid with random tags, restarted from DONE
        pulse_start();
        send_beats(SETS, 1'b1, 1'b0);
        wait_done();
        chk1("gappy_error", g_inst[1].error_w, 1'b0);

        // row 5 corrupted after its write
        corrupt = 1'b1;
        pulse_start();
        send_beats(SETS, 1'b0, 1'b0);
        wait_done();
        chk1("corrupt_error", g_inst[1].error_w, 1'b1);
        corrupt = 1'b0;

        // reset right after beat 30, then a clean reload
        pulse_start();
        send_beats(31, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outs", 128'({g_inst[1].in_ready_w, g_inst[1].busy_w, g_inst[1].done_w,
                               g_inst[1].error_w, g_inst[1].en_w, g_inst[1].wm_w,
                               g_inst[1].addr_w, g_inst[1].mask_w, g_inst[1].wdata_w}), 128'(0));
        repeat (4) tick();
        pulse_start();
        send_beats(SETS, 1'b0, 1'b1);
        wait_done();
        chk1("reload_error", g_inst[1].error_w, 1'b0);
        check_rows();

        // start during READ is ignored: done still lands 67 cycles after the last beat
        pulse_start();
        send_beats(SETS, 1'b0, 1'b0);
        repeat (10) tick();
        pulse_start();
        repeat (54) tick();
        @(negedge clk);
        chk1("ign_start_done_66", g_inst[1].done_w, 1'b0);
        tick();
        @(negedge clk);
        chk1("ign_start_done_67", g_inst[1].done_w, 1'b1);
        chk1("ign_start_error", g_inst[1].error_w, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
